// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - I2C target: oversampled START/STOP detect, address match, byte receive and transmit
`timescale 1ns/1ps
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'b1011001,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK_IW,
  input  logic       RST_IW,
  input  logic       SCL_IW,
  input  logic       SDA_IW,
  output logic       SDA_OE_OW,
  output logic [7:0] RX_DATA_OW,
  output logic       RX_VALID_OW,
  input  logic [7:0] TX_DATA_IW,
  output logic       TX_REQ_OW,
  output logic       BUSY_OW
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, load_tx;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  always_ff @(posedge CLK_IW or negedge RST_IW) begin
    if (!RST_IW) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 7'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL_IW};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_IW};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    load_tx    = 1'b0;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            rw_d      = sda_s;
            state_d   = (shift_q == DEV_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // ACK states enter with SDA released, so sda_oe_q tells which falling edge this is.
        S_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (!rw_q) begin
            sda_oe_d = 1'b0;
            state_d  = S_RX;
          end else begin
            load_tx = 1'b1;
          end
        end
        S_RX: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            rx_data_d  = {shift_q, sda_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = 4'd0;
            state_d    = S_RX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q) state_d = S_RX;
        end
        // bit_cnt counts bits already placed on the line; the MSB went out at load time.
        S_TX: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_TX_ACK;
          end else begin
            sda_oe_d   = ~tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
        S_TX_ACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (sda_s) state_d = S_WAIT_STOP;
            else bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_tx) begin
      tx_shift_d = TX_DATA_IW[6:0];
      tx_req_d   = 1'b1;
      sda_oe_d   = ~TX_DATA_IW[7];
      bit_cnt_d  = 4'd1;
      state_d    = S_TX;
    end
  end

  assign SDA_OE_OW   = sda_oe_q;
  assign RX_DATA_OW  = rx_data_q;
  assign RX_VALID_OW = rx_valid_q;
  assign TX_REQ_OW   = tx_req_q;
  assign BUSY_OW     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - bus-level master driving i2c_slave_rx against a transaction-level expectation model
`timescale 1ns/1ps
module tb_i2c_slave_rx;
  localparam logic [6:0] DEV = 7'b1011001;

  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_oe, rx_valid, tx_req, busy, sda_line;
  logic [7:0] rx_data;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .CLK_IW(clk), .RST_IW(rst_n), .SCL_IW(scl_m), .SDA_IW(sda_line),
    .SDA_OE_OW(sda_oe), .RX_DATA_OW(rx_data), .RX_VALID_OW(rx_valid),
    .TX_DATA_IW(tx_data), .TX_REQ_OW(tx_req), .BUSY_OW(busy)
  );

  int n_tests = 0, n_fail = 0;
  int rx_cnt = 0, txreq_cnt = 0, exp_txreq = 0;
  logic exp_oe = 1'b0, oe_chk = 1'b0, exp_busy = 1'b0, busy_chk = 1'b0;
  logic prev_rxv = 1'b0, prev_txr = 1'b0;
  logic [7:0] exp_q[$];
  logic seen, matched;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle checks of the outputs against the model's current expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oe_chk) chk("sda_oe", 32'(sda_oe), 32'(exp_oe));
      if (busy_chk) chk("busy", 32'(busy), 32'(exp_busy));
      if (rx_valid || tx_req) chk("valid_req_overlap", 32'(rx_valid & tx_req), 0);
      if (rx_valid) begin
        rx_cnt++;
        chk("rx_pulse_len", 32'(prev_rxv), 0);
        if (exp_q.size() == 0) chk("rx_spurious", 32'(rx_valid), 0);
        else chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (tx_req) begin
        txreq_cnt++;
        chk("tx_req_pulse_len", 32'(prev_txr), 0);
      end
    end
    prev_rxv = rx_valid;
    prev_txr = tx_req;
  end

  task automatic clock_bit(input logic b, input logic eo, output logic s);
    cyc(2); sda_m = b; exp_oe = eo;
    cyc(6); scl_m = 1'b1; oe_chk = 1'b1;
    cyc(4); s = sda_line;
    cyc(4); oe_chk = 1'b0; scl_m = 1'b0;
  endtask

  task automatic start_cond();
    oe_chk = 1'b0; busy_chk = 1'b0;
    if (!scl_m) begin
      cyc(2); sda_m = 1'b1;
      cyc(6); scl_m = 1'b1;
    end
    cyc(8); sda_m = 1'b0;
    cyc(8); scl_m = 1'b0;
    exp_busy = 1'b1; busy_chk = 1'b1;
  endtask

  task automatic stop_cond();
    busy_chk = 1'b0;
    cyc(2); sda_m = 1'b0;
    cyc(6); scl_m = 1'b1;
    cyc(8); sda_m = 1'b1;
    cyc(8); exp_busy = 1'b0; busy_chk = 1'b1;
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw, input logic [7:0] first_tx,
                            output logic m);
    logic s;
    logic [7:0] b;
    b = {a, rw};
    m = (a == DEV);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, s);
    tx_data = first_tx;
    if (m && rw) exp_txreq++;
    clock_bit(1'b1, m, s);
    if (m) chk("addr_ack_line", 32'(s), 0);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic m);
    logic s;
    if (m) exp_q.push_back(d);
    for (int i = 7; i >= 0; i--) clock_bit(d[i], 1'b0, s);
    clock_bit(1'b1, m, s);
    if (m) chk("data_ack_line", 32'(s), 0);
  endtask

  task automatic read_byte(input logic [7:0] d, input logic mack, input logic [7:0] nxt);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, ~d[i], s);
      chk("rd_bit", 32'(s), 32'(d[i]));
    end
    tx_data = nxt;
    if (mack) exp_txreq++;
    clock_bit(~mack, 1'b0, s);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tbase, nb, p;
    logic rw, m, rep;
    logic [6:0] a;
    logic [7:0] cur, nxt;

    cyc(3);
    chk("reset_sda_oe", 32'(sda_oe), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_tx_req", 32'(tx_req), 0);
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1'b1; exp_busy = 1'b0; busy_chk = 1'b1;
    cyc(5);

    // Single-byte write
    base = rx_cnt;
    start_cond(); addr_phase(DEV, 1'b0, 8'h00, matched); write_byte(8'hCB, 1'b1); stop_cond();
    cyc(4);
    chk("wr1_rx_data", 32'(rx_data), 32'h0000_00CB);
    chk("wr1_rx_count", rx_cnt - base, 1);

    // Address mismatch
    base = rx_cnt;
    start_cond(); addr_phase(7'h5A, 1'b0, 8'h00, matched); write_byte(8'h11, matched);
    chk("mismatch_busy", 32'(busy), 1);
    stop_cond(); cyc(4);
    chk("mismatch_rx_count", rx_cnt - base, 0);
    chk("mismatch_busy_after", 32'(busy), 0);

    // Two-byte read, ACK then NACK
    tbase = txreq_cnt;
    start_cond(); addr_phase(DEV, 1'b1, 8'hA5, matched);
    read_byte(8'hA5, 1'b1, 8'h3C); read_byte(8'h3C, 1'b0, 8'h00);
    cyc(4);
    chk("rd_released", 32'(sda_oe), 0);
    stop_cond();
    chk("rd_tx_req_count", txreq_cnt - tbase, 2);

    // Repeated START after a partial byte
    base = rx_cnt;
    start_cond(); addr_phase(DEV, 1'b0, 8'h00, matched);
    clock_bit(1'b1, 1'b0, seen); clock_bit(1'b0, 1'b0, seen);
    clock_bit(1'b1, 1'b0, seen); clock_bit(1'b1, 1'b0, seen);
    start_cond(); addr_phase(DEV, 1'b0, 8'h00, matched); write_byte(8'h7E, 1'b1); stop_cond();
    cyc(4);
    chk("rs_rx_count", rx_cnt - base, 1);
    chk("rs_rx_data", 32'(rx_data), 32'h0000_007E);

    // Reset while the target is holding the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hB2 >> i) & 8'h01) != 8'h00, 1'b0, seen);
    cyc(2); sda_m = 1'b1; cyc(6); scl_m = 1'b1; cyc(4);
    chk("rst_oe_before", 32'(sda_oe), 1);
    busy_chk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_oe_async", 32'(sda_oe), 0);
    chk("rst_busy_async", 32'(busy), 0);
    cyc(3); sda_m = 1'b1; scl_m = 1'b1; rst_n = 1'b1;
    exp_busy = 1'b0; busy_chk = 1'b1;
    cyc(5);
    base = rx_cnt;
    start_cond(); addr_phase(DEV, 1'b0, 8'h00, matched); write_byte(8'h42, 1'b1); stop_cond();
    cyc(4);
    chk("post_rst_rx_data", 32'(rx_data), 32'h0000_0042);
    chk("post_rst_rx_count", rx_cnt - base, 1);

    // STOP in the middle of a data byte
    base = rx_cnt;
    start_cond(); addr_phase(DEV, 1'b0, 8'h00, matched);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, 1'b0, seen);
    stop_cond(); cyc(4);
    chk("stopmid_rx_count", rx_cnt - base, 0);
    chk("stopmid_busy", 32'(busy), 0);
    chk("stopmid_sda_oe", 32'(sda_oe), 0);

    // Randomised transactions
    rep = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom % 2);
      a = DEV;
      if ($urandom % 4 == 0) begin
        a = 7'($urandom);
        if (a == DEV) a = a ^ 7'h01;
      end
      nb = int'($urandom_range(1, 3));
      start_cond();
      if (rw && a == DEV) begin
        cur = 8'($urandom);
        addr_phase(a, 1'b1, cur, m);
        for (int k = 0; k < nb; k++) begin
          nxt = 8'($urandom);
          read_byte(cur, k < nb - 1, nxt);
          cur = nxt;
        end
      end else begin
        addr_phase(a, rw, 8'h00, m);
        for (int k = 0; k < nb; k++) write_byte(8'($urandom), m);
        p = int'($urandom_range(0, 6));
        for (int i = 0; i < p; i++) clock_bit(1'($urandom % 2), 1'b0, seen);
      end
      rep = ($urandom % 3 == 0) && (t < 39);
      if (!rep) stop_cond();
    end

    cyc(10);
    chk("rx_queue_drained", exp_q.size(), 0);
    chk("tx_req_total", txreq_cnt, exp_txreq);
    chk("final_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
